// File: rtl/psum_adder_arbiter.sv
// Round-robin arbiter feeding a shared 3-input partial-sum adder with fixed forward latency.
// Optional macro PSUM_SAT_EN: saturate the sum at 2^DWIDTH-1 instead of wrapping modulo 2^DWIDTH.
module psum_adder_arbiter #(
  parameter int DWIDTH = 8,
  parameter int NREQ   = 4,
  parameter int FL_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*3*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       out_valid,
  output logic [DWIDTH-1:0]          out_data,
  output logic [$clog2(NREQ)-1:0]    out_id,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [15:0]                sum_count
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (FL_CYC > 1) ? $clog2(FL_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ADD, SEND} state_t;

  state_t                state;
  logic [IDW-1:0]        last_grant;
  logic [CW-1:0]         lat_cnt;
  logic [3*DWIDTH-1:0]   ops;
  logic [3*DWIDTH-1:0]   req_slice [NREQ];
  logic                  grant_found;
  logic [IDW-1:0]        grant_idx;
  logic [IDW-1:0]        probe;
  logic [DWIDTH+1:0]     sum_wide;
  logic [DWIDTH-1:0]     sum_res;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign req_slice[i] = req_data[i*3*DWIDTH +: 3*DWIDTH];
  end

  // Round-robin search: start one past the last winner and wrap around.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      probe = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[probe]) begin
        grant_found = 1'b1;
        grant_idx   = probe;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  assign sum_wide = {2'b00, ops[0 +: DWIDTH]} + {2'b00, ops[DWIDTH +: DWIDTH]}
                  + {2'b00, ops[2*DWIDTH +: DWIDTH]};

`ifdef PSUM_SAT_EN
  assign sum_res = (sum_wide > {2'b00, {DWIDTH{1'b1}}}) ? {DWIDTH{1'b1}} : sum_wide[DWIDTH-1:0];
`else
  assign sum_res = DWIDTH'(sum_wide);
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      sum_count  <= '0;
      lat_cnt    <= '0;
      last_grant <= IDW'(NREQ - 1);
      ops        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            ops        <= req_slice[grant_idx];
            out_id     <= grant_idx;
            last_grant <= grant_idx;
            lat_cnt    <= CW'(FL_CYC - 1);
            busy       <= 1'b1;
            state      <= ADD;
          end
        end
        ADD: begin
          if (lat_cnt == '0) begin
            out_data  <= sum_res;
            out_valid <= 1'b1;
            state     <= SEND;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        SEND: begin
          // out_data/out_id are only written in IDLE/ADD, so they hold during a stall.
          if (out_ready) begin
            sum_count <= sum_count + 16'd1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_adder_arbiter.sv
// Self-checking bench for psum_adder_arbiter: directed scenarios plus random masks/data
// compared against a transaction-level round-robin / adder model.
module tb_psum_adder_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int FL  = 2;
  localparam int IDW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR*3*DW-1:0]   req_data;
  logic [NR-1:0]        req_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_ready;
  logic                 busy;
  logic [15:0]          sum_count;

  int  errors = 0;
  int  checks = 0;
  int  m_last;
  int  m_count;
  time t_accept = 0;
  time t_prev;

  psum_adder_arbiter #(.DWIDTH(DW), .NREQ(NR), .FL_CYC(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy),
    .sum_count (sum_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NR * 3; i++)
      req_data[i*DW +: DW] = DW'($urandom_range(0, 255));
  endtask

  function automatic int psum(input int g, input int k);
    return int'(req_data[(g*3+k)*DW +: DW]);
  endfunction

  function automatic int model_grant(input int last, input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int model_sum(input int a, input int b, input int c);
    int s;
    s = a + b + c;
`ifdef PSUM_SAT_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  // One full transaction starting in IDLE; returns just after the output handshake edge.
  task automatic do_txn(input logic [NR-1:0] vmask, input logic [NR-1:0] send_mask,
                        input bit fixed, input int p0, input int p1, input int p2,
                        input int stall);
    int g;
    int exp;
    g = model_grant(m_last, vmask);
    req_valid = vmask;
    randomize_data();
    if (fixed) begin
      req_data[(g*3+0)*DW +: DW] = DW'(p0);
      req_data[(g*3+1)*DW +: DW] = DW'(p1);
      req_data[(g*3+2)*DW +: DW] = DW'(p2);
    end
    out_ready = (stall == 0);
    #1;
    check("req_ready_grant", 32'(req_ready), 32'(1 << g));
    check("busy_idle", 32'(busy), 0);
    exp = model_sum(psum(g, 0), psum(g, 1), psum(g, 2));
    tick();
    t_accept = $time;
    m_last = g;
    randomize_data();
    #1;
    check("busy_add", 32'(busy), 1);
    check("req_ready_add", 32'(req_ready), 0);
    check("out_valid_add", 32'(out_valid), 0);
    for (int i = 0; i < FL - 1; i++) begin
      tick();
      check("out_valid_lat", 32'(out_valid), 0);
    end
    tick();
    req_valid = send_mask;
    #1;
    check("out_valid_send", 32'(out_valid), 1);
    check("out_data", 32'(out_data), 32'(exp));
    check("out_id", 32'(out_id), 32'(g));
    check("req_ready_send", 32'(req_ready), 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'(exp));
      check("stall_id", 32'(out_id), 32'(g));
      check("stall_ready", 32'(req_ready), 0);
      check("stall_count", 32'(sum_count), 32'(m_count));
    end
    out_ready = 1'b1;
    tick();
    m_count = (m_count + 1) % 65536;
    check("out_valid_done", 32'(out_valid), 0);
    check("busy_done", 32'(busy), 0);
    check("sum_count", 32'(sum_count), 32'(m_count));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    out_ready = 1'b0;
    m_last    = NR - 1;
    m_count   = 0;
    #2;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    tick();
    tick();
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_id", 32'(out_id), 0);
    check("rst_sum_count", 32'(sum_count), 0);
    check("rst_busy_hold", 32'(busy), 0);

    // Idle with no requests: nothing granted.
    rst = 1'b0;
    req_valid = '0;
    #1;
    check("idle_req_ready", 32'(req_ready), 0);
    tick();
    check("idle_busy", 32'(busy), 0);

    // Single requester 1 with 3,4,5.
    do_txn(4'b0010, 4'b0010, 1'b1, 3, 4, 5, 0);
    // Overflow case 200+100+50.
    do_txn(4'b0100, 4'b0100, 1'b1, 200, 100, 50, 0);
    // Consumer stalls 5 cycles.
    do_txn(4'b1000, 4'b1000, 1'b0, 0, 0, 0, 5);

    // Continuous requests from all four: expect grants 0,1,2,3,0 every FL+2 cycles.
    for (int t = 0; t < 5; t++) begin
      t_prev = t_accept;
      do_txn(4'b1111, 4'b1111, 1'b0, 0, 0, 0, 0);
      if (t > 0) check("throughput", 32'(t_accept - t_prev), 32'((FL + 2) * 10));
    end

    // Requester 1 in SEND while requester 3 drops out; requester 0 must win next.
    do_txn(4'b1011, 4'b0001, 1'b0, 0, 0, 0, 1);
    do_txn(4'b0001, 4'b0001, 1'b0, 0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, 15));
      do_txn(m, m, 1'b0, 0, 0, 0, int'($urandom_range(0, 2)));
    end

    // Reset during ADD of requester 2.
    req_valid = 4'b0100;
    randomize_data();
    out_ready = 1'b1;
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'b0100);
    tick();
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    m_last  = NR - 1;
    m_count = 0;
    tick();
    tick();
    check("mid_rst_count", 32'(sum_count), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_valid2", 32'(out_valid), 0);
    rst = 1'b0;
    do_txn(4'b1111, 4'b1111, 1'b0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_adder_arbiter.md
PSUM_ADDER_ARBITER -- requirements
Module: psum_adder_arbiter

Interface
REQ-001 Parameter DWIDTH, default 8: width of each partial sum and of the result.
REQ-002 Parameter NREQ, default 4: number of PE-column requesters sharing the adder (2..16).
REQ-003 Parameter FL_CYC, default 2: adder forward latency in cycles (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  bit i: requester i presents three psums.
REQ-007 req_data  input  NREQ*3*DWIDTH  requester i occupies slice [i*3*DWIDTH +: 3*DWIDTH], psum k at [k*DWIDTH +: DWIDTH], k=0..2.
REQ-008 req_ready  output  NREQ  one-hot or zero; handshake with requester i when req_valid[i] & req_ready[i].
REQ-009 out_valid  output  1  result available.
REQ-010 out_data  output  DWIDTH  sum of the three granted psums.
REQ-011 out_id  output  $clog2(NREQ)  index of requester that produced out_data.
REQ-012 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 sum_count  output  16  count of completed output handshakes.

Function
REQ-015 FSM shall have states IDLE, ADD, SEND.
REQ-016 IDLE: if any req_valid, grant = first set bit searching upward (mod NREQ) from last_grant+1; req_ready[grant]=1 combinationally, all other bits 0.
REQ-017 req_ready shall be 0 in ADD and SEND and whenever no req_valid is set.
REQ-018 On the accepting edge: capture the three psums and grant index, set last_grant=grant, load latency counter with FL_CYC-1, go to ADD.
REQ-019 ADD: counter decrements each edge; on edge where counter==0, register sum into out_data, go to SEND; ADD lasts exactly FL_CYC cycles.
REQ-020 out_valid shall be high exactly in SEND, first visible FL_CYC edges after the accepting edge.
REQ-021 out_data and out_id shall hold stable while out_valid & !out_ready.
REQ-022 SEND: on out_valid & out_ready edge, sum_count increments (wraps 65535->0), go to IDLE; next grant no earlier than following cycle.
REQ-023 Sum computed unsigned at DWIDTH+2 bits, then reduced to DWIDTH per REQ-030.
REQ-024 A requester dropping req_valid before being granted shall be skipped without penalty; granted data is never re-read after capture.
REQ-025 Throughput: one result per FL_CYC+2 cycles under continuous request and out_ready=1.

Reset
REQ-026 While rst high: state IDLE, req_ready=0, out_valid=0, busy=0.
REQ-027 Reset values: out_data=0, out_id=0, sum_count=0, latency counter=0, last_grant=NREQ-1 (requester 0 has first priority).
REQ-028 rst asserted mid-ADD or mid-SEND shall discard captured operands immediately; no result is emitted afterward.
REQ-029 After rst deasserts, first grant may occur on the first rising edge.

Configuration
REQ-030 Macro PSUM_SAT_EN: when defined, sums exceeding 2^DWIDTH-1 saturate to 2^DWIDTH-1; when undefined, result is the low DWIDTH bits (modulo 2^DWIDTH).

Verification (DWIDTH=8, NREQ=4, FL_CYC=2)
REQ-031 Only req_valid[1], psums 3,4,5 -> req_ready=0010, out_data=12, out_id=1, out_valid 2 edges after acceptance.
REQ-032 All four req_valid held high, out_ready=1 -> grant order 0,1,2,3,0, sum_count=5 after fifth handshake, one result every 4 cycles.
REQ-033 Psums 200,100,50 -> out_data=94 without PSUM_SAT_EN, 255 with it.
REQ-034 out_ready low 5 cycles during SEND -> out_data/out_id unchanged, req_ready=0 throughout, sum_count increments once when out_ready rises.
REQ-035 rst pulsed during ADD of requester 2 -> out_valid stays 0, busy=0 immediately, sum_count=0, next grant goes to requester 0 if valid.
REQ-036 req_valid[3] dropped while requester 1 in SEND, req_valid[0] held -> next grant is requester 0.
